// File: rtl/fill_cmd_loader.sv
// Byte-serial front-end for the fill stage: collects 10-byte commands, launches the
// fill, waits for done with a watchdog, and keeps a completion count plus sticky errors.
module fill_cmd_loader #(
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter int          CNT_W          = 16,
   parameter logic [3:0]  HDR_OPCODE     = 4'hF
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_data,
   output logic             cmd_ready,
   output logic             fill_en,
   input  logic             fill_done,
   output logic             fill_type,
   output logic [1:0]       texture_code,
   output logic             layer_num,
   output logic [47:0]      coordinates,
   output logic [23:0]      color_code,
   output logic             busy,
   output logic             hdr_err,
   output logic             timeout_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] fill_count
);

   localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, LAUNCH, WAIT_DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [63:0]      pay_q, pay_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             ft_q, ft_d;
   logic [1:0]       tc_q, tc_d;
   logic             ln_q, ln_d;
   logic [47:0]      coord_q, coord_d;
   logic [23:0]      color_q, color_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             herr_q, herr_d;
   logic             terr_q, terr_d;
   logic             hdr_set, tmo_set;

   logic        xfer, hdr_ok, last_byte, tmo_hit;
   logic [71:0] full_pay;

   assign xfer      = cmd_valid & cmd_ready;
   assign hdr_ok    = (cmd_data[7:4] == HDR_OPCODE);
   assign last_byte = (idx_q == 4'd9);
   assign tmo_hit   = (tmo_q == TLAST);
   // Bytes 1..8 are staged; byte 9 joins them combinationally on the completing edge.
   assign full_pay  = {pay_q, cmd_data};

   always_ff @(posedge clk) begin
      if (n_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (xfer && hdr_ok)        state_d = LOAD;
         LOAD:      if (xfer && last_byte)     state_d = LAUNCH;
         LAUNCH:                               state_d = WAIT_DONE;
         WAIT_DONE: if (fill_done || tmo_hit)  state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE) || (state_q == LOAD);
      fill_en   = (state_q == LAUNCH);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      idx_d   = idx_q;
      pay_d   = pay_q;
      tmo_d   = tmo_q;
      ft_d    = ft_q;
      tc_d    = tc_q;
      ln_d    = ln_q;
      coord_d = coord_q;
      color_d = color_q;
      cnt_d   = cnt_q;
      hdr_set = 1'b0;
      tmo_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (hdr_ok) begin
                  ft_d  = cmd_data[3];
                  tc_d  = cmd_data[2:1];
                  ln_d  = cmd_data[0];
                  idx_d = 4'd1;
               end else begin
                  hdr_set = 1'b1;
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               pay_d = full_pay[63:0];
               idx_d = idx_q + 4'd1;
               if (last_byte) begin
                  coord_d = full_pay[71:24];
                  color_d = full_pay[23:0];
                  idx_d   = 4'd0;
               end
            end
         end
         LAUNCH: tmo_d = '0;
         WAIT_DONE: begin
            if (fill_done)    cnt_d   = cnt_q + 1'b1;
            else if (tmo_hit) tmo_set = 1'b1;
            else              tmo_d   = tmo_q + 1'b1;
         end
         default: ;
      endcase
      // A new error event in the same cycle as err_clr keeps the flag set.
      herr_d = (herr_q & ~err_clr) | hdr_set;
      terr_d = (terr_q & ~err_clr) | tmo_set;
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         idx_q   <= '0;
         pay_q   <= '0;
         tmo_q   <= '0;
         ft_q    <= 1'b0;
         tc_q    <= '0;
         ln_q    <= 1'b0;
         coord_q <= '0;
         color_q <= '0;
         cnt_q   <= '0;
         herr_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         pay_q   <= pay_d;
         tmo_q   <= tmo_d;
         ft_q    <= ft_d;
         tc_q    <= tc_d;
         ln_q    <= ln_d;
         coord_q <= coord_d;
         color_q <= color_d;
         cnt_q   <= cnt_d;
         herr_q  <= herr_d;
         terr_q  <= terr_d;
      end
   end

   assign fill_type    = ft_q;
   assign texture_code = tc_q;
   assign layer_num    = ln_q;
   assign coordinates  = coord_q;
   assign color_code   = color_q;
   assign hdr_err      = herr_q;
   assign timeout_err  = terr_q;
   assign fill_count   = cnt_q;

endmodule

// File: tb/tb_fill_cmd_loader.sv
// Bench for fill_cmd_loader: a byte-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fill_cmd_loader;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_data = 8'h00;
   logic        fill_done = 1'b0;
   logic        err_clr = 1'b0;
   logic        cmd_ready, fill_en, fill_type, layer_num, busy, hdr_err, timeout_err;
   logic [1:0]  texture_code;
   logic [47:0] coordinates;
   logic [23:0] color_code;
   logic [15:0] fill_count;

   fill_cmd_loader #(.TIMEOUT_CYCLES(T), .CNT_W(16), .HDR_OPCODE(4'hF)) dut (
      .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(cmd_ready), .fill_en(fill_en), .fill_done(fill_done),
      .fill_type(fill_type), .texture_code(texture_code), .layer_num(layer_num),
      .coordinates(coordinates), .color_code(color_code), .busy(busy),
      .hdr_err(hdr_err), .timeout_err(timeout_err), .err_clr(err_clr),
      .fill_count(fill_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;
   bit rnd_on = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: accepted bytes of the current command live in a queue.
   logic [7:0]  mq[$];
   bit          m_launch, m_wait, m_herr, m_terr;
   int          m_wc;
   logic        m_ft, m_ln;
   logic [1:0]  m_tc;
   logic [47:0] m_coord;
   logic [23:0] m_color;
   logic [15:0] m_cnt;

   always @(posedge clk) begin : model
      bit hs, ts;
      hs = 0; ts = 0;
      if (n_rst) begin
         mq.delete();
         m_launch = 0; m_wait = 0; m_wc = 0; m_herr = 0; m_terr = 0;
         m_ft = 0; m_ln = 0; m_tc = 0; m_coord = 0; m_color = 0; m_cnt = 0;
      end else begin
         if (m_launch) begin
            m_launch = 0; m_wait = 1; m_wc = 0;
         end else if (m_wait) begin
            m_wc++;
            if (fill_done) begin m_cnt++; m_wait = 0; end
            else if (m_wc == T) begin ts = 1; m_wait = 0; end
         end else if (cmd_valid) begin
            if (mq.size() == 0) begin
               if (cmd_data[7:4] == 4'hF) begin
                  mq.push_back(cmd_data);
                  m_ft = cmd_data[3]; m_tc = cmd_data[2:1]; m_ln = cmd_data[0];
               end else hs = 1;
            end else begin
               mq.push_back(cmd_data);
               if (mq.size() == 10) begin
                  m_coord = {mq[1], mq[2], mq[3], mq[4], mq[5], mq[6]};
                  m_color = {mq[7], mq[8], mq[9]};
                  mq.delete();
                  m_launch = 1;
               end
            end
         end
         if (err_clr) begin m_herr = 0; m_terr = 0; end
         if (hs) m_herr = 1;
         if (ts) m_terr = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready",    64'(cmd_ready),    64'(!(m_launch || m_wait)));
         chk("fill_en",      64'(fill_en),      64'(m_launch));
         chk("busy",         64'(busy),         64'((mq.size() != 0) || m_launch || m_wait));
         chk("fill_type",    64'(fill_type),    64'(m_ft));
         chk("texture_code", 64'(texture_code), 64'(m_tc));
         chk("layer_num",    64'(layer_num),    64'(m_ln));
         chk("coordinates",  64'(coordinates),  64'(m_coord));
         chk("color_code",   64'(color_code),   64'(m_color));
         chk("hdr_err",      64'(hdr_err),      64'(m_herr));
         chk("timeout_err",  64'(timeout_err),  64'(m_terr));
         chk("fill_count",   64'(fill_count),   64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         cmd_valid = 1'b0;
         cmd_data  = 8'($urandom);
         err_clr   = rnd_on && ($urandom_range(0, 7) == 0);
         tick();
      end
      cmd_valid = 1'b1;
      cmd_data  = b;
      err_clr   = rnd_on && ($urandom_range(0, 7) == 0);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      if (n == 50) chk("ready_wait", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] h, input logic [71:0] p, input int gmax);
      send_byte(h, 0);
      for (int i = 0; i < 9; i++) send_byte(p[71-8*i -: 8], $urandom_range(0, gmax));
   endtask

   task automatic pulse_done_after(input int d);
      repeat (d) tick();
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0;
   endtask

   localparam logic [71:0] P1 = 72'h112233445566AABBCC;

   initial begin
      int n;
      tick();
      tick();
      n_rst = 1'b0;
      chk_en = 1;
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_ready", 64'(cmd_ready),  64'd1);
      chk("rst_count", 64'(fill_count), 64'd0);
      chk("rst_coord", 64'(coordinates), 64'd0);

      // Directed: basic command
      send_cmd(8'hF9, P1, 0);
      chk("d1_fill_en", 64'(fill_en),      64'd1);
      chk("d1_ftype",   64'(fill_type),    64'd1);
      chk("d1_tex",     64'(texture_code), 64'd0);
      chk("d1_layer",   64'(layer_num),    64'd1);
      chk("d1_coord",   64'(coordinates),  64'h112233445566);
      chk("d1_color",   64'(color_code),   64'hAABBCC);
      chk("d1_ready",   64'(cmd_ready),    64'd0);
      tick();
      chk("d1_en_once", 64'(fill_en),      64'd0);
      tick();
      pulse_done_after(0);
      chk("d1_count",   64'(fill_count),   64'd1);
      chk("d1_busy",    64'(busy),         64'd0);
      chk("d1_ready2",  64'(cmd_ready),    64'd1);

      // Bad header
      send_byte(8'h3E, 0);
      chk("d2_herr",    64'(hdr_err), 64'd1);
      chk("d2_busy",    64'(busy),    64'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("d2_clr",     64'(hdr_err), 64'd0);

      // Timeout: fill_done never comes
      send_cmd(8'hF2, 72'h0102030405060708_09, 0);
      n = 0;
      do begin tick(); n++; end while (busy && n < 30);
      chk("d3_wait_cycles", 64'(n - 1), 64'd8);
      chk("d3_terr",        64'(timeout_err), 64'd1);
      chk("d3_count",       64'(fill_count),  64'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // fill_done during LAUNCH is ignored; on first WAIT cycle it counts
      send_cmd(8'hF4, P1, 0);
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0;
      repeat (3) tick();
      chk("d4_nocount", 64'(fill_count), 64'd1);
      chk("d4_busy",    64'(busy),       64'd1);
      pulse_done_after(0);
      chk("d4_count2",  64'(fill_count), 64'd2);
      send_cmd(8'hF4, P1, 0);
      tick();
      pulse_done_after(0);
      chk("d4_count3",  64'(fill_count), 64'd3);
      chk("d4_idle",    64'(busy),       64'd0);

      // Gapped load gives the same fields
      send_cmd(8'hF9, P1, 4);
      chk("d5_coord",   64'(coordinates), 64'h112233445566);
      chk("d5_color",   64'(color_code),  64'hAABBCC);
      chk("d5_ftype",   64'(fill_type),   64'd1);
      pulse_done_after(2);

      // Reset mid-load and mid-wait
      send_byte(8'hF6, 0);
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1);
      n_rst = 1'b1;
      tick();
      n_rst = 1'b0;
      chk("d6_busy",  64'(busy),       64'd0);
      chk("d6_count", 64'(fill_count), 64'd0);
      chk("d6_coord", 64'(coordinates), 64'd0);
      chk("d6_ftype", 64'(fill_type),  64'd0);
      send_cmd(8'hFB, P1, 0);
      tick();
      n_rst = 1'b1;
      tick();
      n_rst = 1'b0;
      chk("d6_busy2",  64'(busy),        64'd0);
      chk("d6_color2", 64'(color_code),  64'd0);
      send_cmd(8'hFE, 72'hDEADBEEFCAFE123456, 0);
      pulse_done_after(1);
      chk("d6_count2", 64'(fill_count),  64'd1);
      chk("d6_coord2", 64'(coordinates), 64'hDEADBEEFCAFE);

      // Randomized traffic
      rnd_on = 1;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            send_byte({4'($urandom_range(0, 14)), 4'($urandom)}, $urandom_range(0, 2));
         end else begin
            send_cmd({4'hF, 4'($urandom)}, {$urandom, $urandom, 8'($urandom)}, 3);
            pulse_done_after($urandom_range(0, 10));
         end
      end
      rnd_on = 0;
      repeat (12) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/fill_cmd_loader.md
Name: fill_cmd_loader

Overview:
Upstream command front-end for the fill stage. It accepts a byte-serial command stream and assembles 10-byte fill commands. For each complete command it drives the fill stage's parameter inputs, pulses fill_en, and waits for the fill stage's done before accepting the next command. It also provides a completion counter, a done-timeout watchdog and a malformed-header flag.

Parameters:
TIMEOUT_CYCLES, 65535, max cycles in WAIT_DONE before abort (>=2)
CNT_W, 16, width of fill_count
HDR_OPCODE, 4'hF, required value of header bits [7:4]

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous reset, active-high (1 = reset); sampled on clk only
cmd_valid  input  1  command byte valid
cmd_data  input  8  command byte
cmd_ready  output  1  loader can accept a byte this cycle
fill_en  output  1  one-cycle launch pulse to fill stage
fill_done  input  1  done from fill stage
fill_type  output  1  header bit [3]
texture_code  output  2  header bits [2:1]
layer_num  output  1  header bit [0]
coordinates  output  48  bytes 1..6, MSB first (byte1 -> [47:40])
color_code  output  24  bytes 7..9, MSB first (byte7 -> [23:16])
busy  output  1  high whenever state != IDLE
hdr_err  output  1  sticky: header byte with bad opcode was dropped
timeout_err  output  1  sticky: fill_done not seen within TIMEOUT_CYCLES
err_clr  input  1  clears hdr_err and timeout_err
fill_count  output  CNT_W  number of commands completed with fill_done

Behaviour:
- A byte transfers on a clk edge where cmd_valid & cmd_ready. cmd_ready = 1 in IDLE and LOAD, 0 otherwise (combinational from state).
- Reset (n_rst=1 at edge): state=IDLE; fill_en, busy, hdr_err, timeout_err = 0; fill_count = 0; coordinates, color_code, fill_type, texture_code, layer_num = 0; byte index = 0. Reset overrides everything, including mid-load or mid-wait. An in-flight partial command is discarded.
- FSM states and transitions:
  - IDLE: on a header byte transfer with cmd_data[7:4]==HDR_OPCODE, latch fill_type, texture_code and layer_num, set byte index=1, go to LOAD. If the opcode mismatches, drop the byte, set hdr_err, and stay in IDLE.
  - LOAD: on each transfer, shift the byte into the 72-bit payload register and increment the index. The transfer of byte 9 completes the command: update coordinates and color_code from the full payload in the same edge, then go to LAUNCH. Output fields change only on this edge or on a header edge; payload bytes are staged internally until then.
  - LAUNCH: fill_en=1 for exactly this one cycle; clear the timeout counter; go to WAIT_DONE unconditionally. fill_done is ignored in LAUNCH.
  - WAIT_DONE: fill_en=0. If fill_done=1: fill_count += 1 (wraps modulo 2^CNT_W), go to IDLE. Else if timeout counter == TIMEOUT_CYCLES-1: set timeout_err, go to IDLE with no count increment. Else increment the counter.
- Latency: header accepted at edge 0, byte 9 at edge 9 (with back-to-back valid), fill_en high in the cycle after edge 9. The earliest next header is accepted in the cycle after fill_done is sampled.
- Command fields stay stable from the completing edge until the next accepted header, so they are stable throughout the fill.
- cmd_valid gaps in LOAD stall the load indefinitely; there is no inter-byte timeout.
- err_clr: clears both sticky flags at the edge. If a new error event occurs in the same cycle, the set wins.
- hdr_err is only checked in IDLE. Bytes in LOAD are never interpreted as headers.

Test Plan:
- Reset, then send F9 11 22 33 44 55 66 AA BB CC back-to-back -> fill_en pulses one cycle after the 10th byte; fill_type=1, texture_code=2'b00, layer_num=1, coordinates=48'h112233445566, color_code=24'hAABBCC; fill_done 3 cycles later -> fill_count=1, busy=0, cmd_ready=1.
- Header 0x3E sent in IDLE -> byte dropped, hdr_err=1, state IDLE. Assert err_clr -> hdr_err=0.
- Valid command with TIMEOUT_CYCLES=8 and fill_done held 0 -> exactly 8 WAIT_DONE cycles, then timeout_err=1, fill_count unchanged, IDLE.
- fill_done held high during LAUNCH and released -> not counted. fill_done high on the first WAIT_DONE cycle -> counted once.
- Random cmd_valid gaps mid-load -> identical outputs to the back-to-back case, and cmd_ready=0 while in LAUNCH/WAIT_DONE.
- n_rst asserted after byte 5 and again during WAIT_DONE -> all outputs zero, IDLE. A following full command works normally.
